// File: rtl/itl_ctrl.sv
// Interleaver write/read sequencer: fills the dual RAM with one PB of symbols,
// then sweeps the read addresses through the permutation ROM and flags the last output.
module itl_ctrl #(
   parameter int D_WIDTH = 2,
   parameter int A_WIDTH = 12
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [1:0]         pb_size,
   input  logic               in_vld,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               in_rdy,
   output logic [D_WIDTH-1:0] ram_wdata,
   output logic [A_WIDTH-1:0] ram_waddr,
   output logic               ram_wen,
   output logic               ram_din_vld,
   output logic [A_WIDTH-1:0] ram_pb_offset,
   input  logic               ram_dout_vld,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [A_WIDTH-1:0] cnt, cnt_nxt;
   logic [A_WIDTH-1:0] n_sym, n_sym_nxt;
   logic [A_WIDTH-1:0] offset, offset_nxt;
   logic               drain_cnt, drain_nxt;
   logic               last_d1, last_d2;
   logic               err_q;
   logic               cnt_at_end;
   logic               read_last;

   assign cnt_at_end = (cnt == n_sym - A_WIDTH'(1));
   assign read_last  = (state == S_READ) && cnt_at_end;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         n_sym     <= '0;
         offset    <= '0;
         drain_cnt <= 1'b0;
         last_d1   <= 1'b0;
         last_d2   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         n_sym     <= n_sym_nxt;
         offset    <= offset_nxt;
         drain_cnt <= drain_nxt;
         last_d1   <= read_last;
         last_d2   <= last_d1;
         err_q     <= (state == S_IDLE) && start && (pb_size == 2'd3);
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path infers a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      n_sym_nxt   = n_sym;
      offset_nxt  = offset;
      drain_nxt   = drain_cnt;
      in_rdy      = 1'b0;
      ram_wen     = 1'b0;
      ram_din_vld = 1'b0;
      ram_waddr   = '0;

      case (state)
         S_IDLE: begin
            if (start && (pb_size != 2'd3)) begin
               case (pb_size)
                  2'd0:    begin n_sym_nxt = A_WIDTH'(64);   offset_nxt = A_WIDTH'(0);   end
                  2'd1:    begin n_sym_nxt = A_WIDTH'(544);  offset_nxt = A_WIDTH'(64);  end
                  default: begin n_sym_nxt = A_WIDTH'(2080); offset_nxt = A_WIDTH'(608); end
               endcase
               cnt_nxt   = '0;
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            in_rdy    = 1'b1;
            ram_wen   = in_vld;
            ram_waddr = cnt;
            if (in_vld) begin
               if (cnt_at_end) begin
                  cnt_nxt   = '0;
                  state_nxt = S_READ;
               end else begin
                  cnt_nxt = cnt + A_WIDTH'(1);
               end
            end
         end
         S_READ: begin
            ram_din_vld = 1'b1;
            ram_waddr   = cnt;
            if (cnt_at_end) begin
               cnt_nxt   = '0;
               drain_nxt = 1'b0;
               state_nxt = S_DRAIN;
            end else begin
               cnt_nxt = cnt + A_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            // Two cycles cover the RAM read latency before the PB is declared complete.
            drain_nxt = ~drain_cnt;
            if (drain_cnt) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign ram_wdata     = in_data;
   assign ram_pb_offset = offset;
   assign out_last      = last_d2 & ram_dout_vld;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign err           = err_q;

endmodule
